// File: rtl/key_led_pkg.sv
// Shared defaults, width helper and LED reset pattern for key_led_runner.
package key_led_pkg;

  localparam int KEY_W_DEF         = 2;
  localparam int LED_W_DEF         = 10;
  localparam int DEB_CYCLES_DEF    = 16;
  localparam int REPEAT_CYCLES_DEF = 64;

  localparam int LED_RST_PATTERN   = 1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, stability debouncer, press pulse.
// Auto-repeat while held is built only with KEY_LED_RUNNER_AUTO_REPEAT_EN.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_clean,
  output logic o_press
);

  localparam int             DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("key_debounce: DEB_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_cnt;
  logic          r_clean;
  logic          r_press;

  logic w_pressed;
  logic w_differ;
  logic w_accept;
  logic w_clean_next;
  logic w_rise;
  logic w_rep;

  // Flops hold raw polarity so reset means "released"; invert on the way out.
  assign w_pressed    = ~r_s2;
  assign w_differ     = (w_pressed != r_clean);
  assign w_accept     = w_differ && (r_cnt == DEB_LAST);
  assign w_clean_next = w_accept ? w_pressed : r_clean;
  assign w_rise       = w_accept && w_pressed;

`ifdef KEY_LED_RUNNER_AUTO_REPEAT_EN
  localparam int            HW       = cnt_width(REPEAT_CYCLES);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] r_hold;

  // No repeat on the edge the key is being released.
  assign w_rep = r_clean && w_clean_next && (r_hold == REP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_clean_next || w_rise || w_rep) begin
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_key_n;
      r_s2    <= r_s1;
      r_cnt   <= (!w_differ || w_accept) ? '0 : r_cnt + DW'(1);
      r_clean <= w_clean_next;
      r_press <= w_rise | w_rep;
    end
  end

  assign o_clean = r_clean;
  assign o_press = r_press;

endmodule

// File: rtl/key_led_runner.sv
// Debounced push-buttons driving a one-hot running light: key 0 left, key 1 right.
// Optional auto-repeat while held: define KEY_LED_RUNNER_AUTO_REPEAT_EN.
module key_led_runner
  import key_led_pkg::*;
#(
  parameter int KEY_W         = KEY_W_DEF,
  parameter int LED_W         = LED_W_DEF,
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_clean,
  output logic [KEY_W-1:0] key_press,
  output logic [LED_W-1:0] led
);

  if (KEY_W < 2 || LED_W < 2) begin : g_bad_param
    $error("key_led_runner: KEY_W and LED_W must be at least 2");
  end

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key_n (key[i]),
      .o_clean (key_clean[i]),
      .o_press (key_press[i])
    );
  end

  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_next;

  always_comb begin
    w_led_next = r_led;
    case (key_press[1:0])
      2'b11:   w_led_next = LED_W'(LED_RST_PATTERN);
      2'b01:   w_led_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
      2'b10:   w_led_next = {r_led[0], r_led[LED_W-1:1]};
      default: w_led_next = r_led;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led <= LED_W'(LED_RST_PATTERN);
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_key_led_runner.sv
// Self-checking bench for key_led_runner: directed scenarios plus random bouncing keys.
module tb_key_led_runner;

  localparam int KW  = 3;
  localparam int LW  = 10;
  localparam int DEB = 4;
  localparam int REP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] key = '1;
  logic [KW-1:0] key_clean;
  logic [KW-1:0] key_press;
  logic [LW-1:0] led;

  key_led_runner #(
    .KEY_W(KW), .LED_W(LW), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_clean(key_clean), .key_press(key_press), .led(led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: keys as sample histories, LED as a lit position.
  logic [KW-1:0] m_s1, m_s2, m_clean, m_press;
  int            m_pos;
  int            m_last[KW];
  bit            m_hist[KW][$];
  int            cyc = 0;

  task automatic model_edge(input logic [KW-1:0] raw, input logic rst);
    logic [KW-1:0] nc, np;
    int npos;
    bit acc, rise, rep;
    if (!rst) begin
      m_s1 = '1; m_s2 = '1; m_clean = '0; m_press = '0; m_pos = 0;
      for (int i = 0; i < KW; i++) begin
        m_hist[i].delete();
        m_last[i] = 0;
      end
    end else begin
      npos = m_pos;
      if (m_press[0] && m_press[1]) npos = 0;
      else if (m_press[0])          npos = (m_pos + 1) % LW;
      else if (m_press[1])          npos = (m_pos + LW - 1) % LW;
      for (int i = 0; i < KW; i++) begin
        m_hist[i].push_back(~m_s2[i]);
        if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
        acc = (m_hist[i].size() == DEB);
        foreach (m_hist[i][j]) if (m_hist[i][j] == m_clean[i]) acc = 0;
        nc[i] = acc ? ~m_clean[i] : m_clean[i];
        rise  = acc && nc[i];
        rep   = 0;
`ifdef KEY_LED_RUNNER_AUTO_REPEAT_EN
        rep   = m_clean[i] && nc[i] && !rise && ((cyc - m_last[i]) == REP);
`endif
        if (rise || rep) m_last[i] = cyc;
        np[i] = rise | rep;
      end
      m_s2 = m_s1; m_s1 = raw; m_clean = nc; m_press = np; m_pos = npos;
    end
    cyc++;
  endtask

  task automatic step(input logic [KW-1:0] raw, input logic rst);
    logic [LW-1:0] e_led;
    @(negedge clk);
    key   = raw;
    rst_n = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    e_led = '0;
    e_led[m_pos] = 1'b1;
    check("key_clean", 32'(key_clean), 32'(m_clean));
    check("key_press", 32'(key_press), 32'(m_press));
    check("led",       32'(led),       32'(e_led));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step('1, 1'b0);
    step('1, 1'b1);
  endtask

  task automatic press(input logic [KW-1:0] raw);
    for (int i = 0; i < 6; i++) step(raw, 1'b1);
    for (int i = 0; i < 12; i++) step('1, 1'b1);
  endtask

  int n_pulse;
  int rem[KW];
  logic [KW-1:0] rkey;

  initial begin
    // Reset
    do_reset();
    check("rst_led",   32'(led), 32'd1);
    check("rst_clean", 32'(key_clean), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    for (int i = 0; i < 4; i++) step('1, 1'b1);

    // Clean press on key 0: accepted at the 6th edge, LED moves at the 7th
    for (int k = 1; k <= 7; k++) begin
      step(3'b110, 1'b1);
      if (k == 5) check("press_lat_before", 32'(key_clean[0]), 32'd0);
      if (k == 6) begin
        check("press_lat_clean", 32'(key_clean[0]), 32'd1);
        check("press_lat_pulse", 32'(key_press[0]), 32'd1);
      end
      if (k == 7) begin
        check("press_pulse_once", 32'(key_press[0]), 32'd0);
        check("press_led", 32'(led), 32'b0000000010);
      end
    end
    for (int i = 0; i < 12; i++) step('1, 1'b1);

    // Bounce rejection
    for (int k = 0; k < 20; k++) begin
      step(((k / 2) % 2 == 0) ? 3'b110 : 3'b111, 1'b1);
      check("bounce_no_pulse", 32'(key_press), 32'd0);
    end
    for (int i = 0; i < 10; i++) step('1, 1'b1);
    check("bounce_led", 32'(led), 32'b0000000010);

    // Wrap-around left and right
    do_reset();
    for (int p = 0; p < LW; p++) press(3'b110);
    check("wrap_left", 32'(led), 32'd1);
    do_reset();
    press(3'b101);
    check("wrap_right", 32'(led), 32'b1000000000);

    // Key 2 never moves the light
    press(3'b011);
    check("key2_led", 32'(led), 32'b1000000000);

    // Simultaneous press returns to bit 0
    do_reset();
    press(3'b110);
    n_pulse = 0;
    for (int k = 1; k <= 7; k++) begin
      step(3'b100, 1'b1);
      if (k == 6) check("simul_pulse", 32'(key_press[1:0]), 32'd3);
      if (k == 7) check("simul_led", 32'(led), 32'd1);
    end
    for (int i = 0; i < 12; i++) step('1, 1'b1);

    // Held key: auto-repeat when built in, single pulse otherwise
    do_reset();
    n_pulse = 0;
    for (int k = 1; k <= 46; k++) begin
      step(3'b110, 1'b1);
      if (k >= 6 && k <= 45 && key_press[0]) n_pulse++;
      if (k == 45) begin
`ifdef KEY_LED_RUNNER_AUTO_REPEAT_EN
        check("hold_pulses", 32'(n_pulse), 32'd5);
        check("hold_led", 32'(led), 32'b0000100000);
`else
        check("hold_pulses", 32'(n_pulse), 32'd1);
        check("hold_led", 32'(led), 32'b0000000010);
`endif
      end
    end
    for (int i = 0; i < 14; i++) step('1, 1'b1);

    // Random bouncing keys with occasional resets
    rkey = '1;
    for (int i = 0; i < KW; i++) rem[i] = $urandom_range(1, 12);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < KW; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          rkey[i] = ~rkey[i];
          rem[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
      end
      step(rkey, ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
